// File: rtl/wow_snd_pkg.sv
// Shared types and widths for the WoW sound-path sample fetch logic.
package wow_snd_pkg;

  localparam int unsigned SAMPLE_AW = 24;
  localparam int unsigned DATA_W    = 16;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } fetch_state_t;

endpackage

// File: rtl/wow_rr_pick.sv
// Combinational round-robin pick: first asserted request at or after ptr, wrapping.
module wow_rr_pick
  import wow_snd_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned PW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PW-1:0]      ptr,
  output logic               valid,
  output logic [PW-1:0]      idx
);

  logic [PW-1:0] cand;

  always_comb begin
    valid = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      cand = PW'((32'(ptr) + 32'(i)) % NUM_REQ);
      if (!valid && req[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/wow_sample_fetch_arbiter.sv
// Round-robin arbiter sharing one sample-memory read port among voice players,
// with a single outstanding read and a bounded wait for bridge data.
module wow_sample_fetch_arbiter
  import wow_snd_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned AW      = SAMPLE_AW,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                  CLK,
  input  logic                  I_RESET_L,
  input  logic                  s_enable,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ*AW-1:0] req_addr,
  output logic [NUM_REQ-1:0]    ack,
  output logic [DATA_W-1:0]     rd_data,
  output logic [AW-1:0]         s_addr,
  output logic                  s_read,
  input  logic [DATA_W-1:0]     s_data,
  input  logic                  s_ready,
  output logic                  busy,
  output logic                  timeout_err
);

  localparam int unsigned PW = $clog2(NUM_REQ);
  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  fetch_state_t        state;
  logic [PW-1:0]       ptr;
  logic [PW-1:0]       gnt_idx;
  logic [CW-1:0]       wait_cnt;
  logic                mask_last;
  logic [NUM_REQ-1:0]  req_eff;
  logic                pick_valid;
  logic [PW-1:0]       pick_idx;
  logic [AW-1:0]       addr_arr [NUM_REQ];

  // The voice just served may still be holding req in the cycle after its ack.
  assign req_eff = mask_last ? (req & ~(NUM_REQ'(1) << gnt_idx)) : req;

  for (genvar g = 0; g < int'(NUM_REQ); g++) begin : g_addr
    assign addr_arr[g] = req_addr[g*AW +: AW];
  end

  wow_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PW      (PW)
  ) u_pick (
    .req   (req_eff),
    .ptr   (ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  always_ff @(posedge CLK) begin
    if (!I_RESET_L) begin
      state       <= IDLE;
      ptr         <= '0;
      gnt_idx     <= '0;
      wait_cnt    <= '0;
      mask_last   <= 1'b0;
      ack         <= '0;
      rd_data     <= '0;
      s_addr      <= '0;
      s_read      <= 1'b0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      s_read <= 1'b0;
      ack    <= '0;
      case (state)
        IDLE: begin
          mask_last <= 1'b0;
          if (s_enable && pick_valid) begin
            gnt_idx <= pick_idx;
            s_addr  <= addr_arr[pick_idx];
            s_read  <= 1'b1;
            busy    <= 1'b1;
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          wait_cnt <= '0;
          state    <= WAIT;
        end
        WAIT: begin
          if (s_ready) begin
            rd_data <= s_data;
            ack     <= NUM_REQ'(1) << gnt_idx;
            state   <= DONE;
          end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
            // Forced completion: the voice gets silence rather than stalling forever.
            rd_data     <= '0;
            timeout_err <= 1'b1;
            ack         <= NUM_REQ'(1) << gnt_idx;
            state       <= DONE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        DONE: begin
          ptr       <= (gnt_idx == PW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
          mask_last <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wow_sample_fetch_arbiter.sv
// Scoreboard bench for wow_sample_fetch_arbiter: directed reads, a bridge model, and a monitor.
module tb_wow_sample_fetch_arbiter;
  import wow_snd_pkg::*;

  localparam int unsigned NR = 4;
  localparam int unsigned AW = 24;
  localparam int unsigned TO = 8;

  typedef struct packed {
    logic [NR-1:0] ack;
    logic [15:0]   data;
  } exp_t;

  logic             CLK = 1'b0;
  logic             I_RESET_L;
  logic             s_enable;
  logic [NR-1:0]    req;
  logic [NR*AW-1:0] req_addr;
  logic [NR-1:0]    ack;
  logic [15:0]      rd_data;
  logic [AW-1:0]    s_addr;
  logic             s_read;
  logic [15:0]      s_data;
  logic             s_ready;
  logic             busy;
  logic             timeout_err;

  exp_t          sb[$];
  logic [AW-1:0] addr_q[$];
  int            n_cmp = 0;
  int            n_mis = 0;

  int          br_delay = 1;
  logic        br_never = 1'b0;
  logic        br_echo  = 1'b0;
  logic [15:0] br_data  = 16'h0000;

  wow_sample_fetch_arbiter #(
    .NUM_REQ (NR),
    .AW      (AW),
    .TIMEOUT (TO)
  ) dut (
    .CLK         (CLK),
    .I_RESET_L   (I_RESET_L),
    .s_enable    (s_enable),
    .req         (req),
    .req_addr    (req_addr),
    .ack         (ack),
    .rd_data     (rd_data),
    .s_addr      (s_addr),
    .s_read      (s_read),
    .s_data      (s_data),
    .s_ready     (s_ready),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_addr(input int i, input logic [AW-1:0] a);
    req_addr[i*AW +: AW] = a;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    I_RESET_L = 1'b0;
    req       = '0;
    @(negedge CLK);
    I_RESET_L = 1'b1;
  endtask

  // Count negedges until s_read is seen; an expired bound is a failure.
  task automatic wait_sread(input string name, input int limit, output int n);
    n = 0;
    for (int c = 1; c <= limit; c++) begin
      @(negedge CLK);
      if (s_read === 1'b1) begin
        n = c;
        return;
      end
    end
    n_cmp++;
    n_mis++;
    $display("FAIL %s: no s_read within %0d cycles", name, limit);
  endtask

  task automatic wait_ack(input string name, input int limit, output int n);
    n = 0;
    for (int c = 1; c <= limit; c++) begin
      @(negedge CLK);
      if (|ack) begin
        n = c;
        return;
      end
    end
    n_cmp++;
    n_mis++;
    $display("FAIL %s: no ack within %0d cycles", name, limit);
  endtask

  // Bridge model: answers each read strobe after br_delay cycles unless br_never.
  initial begin : bridge
    logic [15:0] d;
    s_ready = 1'b0;
    s_data  = 16'h0000;
    forever begin
      @(negedge CLK);
      if (s_read === 1'b1 && !br_never) begin
        d = br_echo ? s_addr[15:0] : br_data;
        repeat (br_delay) @(negedge CLK);
        s_ready = 1'b1;
        s_data  = d;
        @(negedge CLK);
        s_ready = 1'b0;
      end
    end
  end

  // Monitor: every read strobe and every ack is matched against the queues.
  initial begin : monitor
    exp_t          e;
    logic [AW-1:0] a;
    forever begin
      @(negedge CLK);
      if (s_read === 1'b1) begin
        if (addr_q.size() == 0) begin
          check("s_read_unexpected", 32'(s_read), 32'd0);
        end else begin
          a = addr_q.pop_front();
          check("s_addr", 32'(s_addr), 32'(a));
        end
      end
      if (|ack) begin
        if (sb.size() == 0) begin
          check("ack_unexpected", 32'(ack), 32'd0);
        end else begin
          e = sb.pop_front();
          check("ack_vec", 32'(ack), 32'(e.ack));
          check("rd_data", 32'(rd_data), 32'(e.data));
        end
      end
    end
  end

  initial begin : stim
    int n;
    int got;
    logic [NR-1:0] rearm;

    I_RESET_L = 1'b0;
    s_enable  = 1'b1;
    req       = 4'hF;
    req_addr  = '0;
    set_addr(0, 24'h111111);
    repeat (4) @(negedge CLK);
    check("rst_s_read", 32'(s_read), 32'd0);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_s_addr", 32'(s_addr), 32'd0);
    check("rst_rd_data", 32'(rd_data), 32'd0);
    check("rst_timeout_err", 32'(timeout_err), 32'd0);
    req = '0;
    @(negedge CLK);
    I_RESET_L = 1'b1;
    @(negedge CLK);

    // Single read, bridge answers 3 cycles after the strobe.
    br_delay = 3;
    br_data  = 16'hBEEF;
    set_addr(1, 24'h001234);
    addr_q.push_back(24'h001234);
    sb.push_back(exp_t'({4'b0010, 16'hBEEF}));
    req = 4'b0010;
    wait_sread("t2_sread", 20, n);
    check("t2_sread_latency", 32'(n), 32'd1);
    check("t2_busy", 32'(busy), 32'd1);
    wait_ack("t2_ack", 20, n);
    check("t2_ack_latency", 32'(n), 32'd4);
    req = '0;
    repeat (3) @(negedge CLK);
    check("t2_rd_data_held", 32'(rd_data), 32'h0000BEEF);
    check("t2_busy_idle", 32'(busy), 32'd0);
    check("t2_no_timeout", 32'(timeout_err), 32'd0);

    // Fairness from a fresh pointer: all voices requesting, each re-raises after its ack.
    do_reset();
    br_delay = 1;
    br_echo  = 1'b1;
    for (int i = 0; i < int'(NR); i++) set_addr(i, 24'h0A0100 + 24'(i));
    for (int k = 0; k < 6; k++) begin
      addr_q.push_back(24'h0A0100 + 24'(k % 4));
      sb.push_back(exp_t'({4'(4'b0001 << (k % 4)), 16'h0100 + 16'(k % 4)}));
    end
    @(negedge CLK);
    req   = 4'hF;
    rearm = '0;
    got   = 0;
    for (int c = 0; c < 200 && got < 6; c++) begin
      @(negedge CLK);
      req   = req | rearm;
      rearm = '0;
      if (|ack) begin
        got++;
        req   = req & ~ack;
        rearm = ack;
        if (got == 6) begin
          req   = '0;
          rearm = '0;
        end
      end
    end
    check("t3_ack_count", 32'(got), 32'd6);
    br_echo = 1'b0;
    repeat (4) @(negedge CLK);

    // Gating: no grant while memory is unavailable; read completes even if it drops mid-op.
    br_delay = 2;
    br_data  = 16'h1357;
    s_enable = 1'b0;
    set_addr(3, 24'hABCDEF);
    req = 4'b1000;
    repeat (50) @(negedge CLK);
    check("t5_gated_busy", 32'(busy), 32'd0);
    check("t5_gated_s_read", 32'(s_read), 32'd0);
    addr_q.push_back(24'hABCDEF);
    sb.push_back(exp_t'({4'b1000, 16'h1357}));
    s_enable = 1'b1;
    wait_sread("t5_sread", 10, n);
    check("t5_sread_latency", 32'(n), 32'd1);
    s_enable = 1'b0;
    wait_ack("t5_ack", 20, n);
    check("t5_ack_latency", 32'(n), 32'd3);
    req      = '0;
    s_enable = 1'b1;
    repeat (3) @(negedge CLK);

    // Timeout: bridge never answers, ack forced TIMEOUT cycles after entering WAIT.
    br_never = 1'b1;
    set_addr(0, 24'h000040);
    addr_q.push_back(24'h000040);
    sb.push_back(exp_t'({4'b0001, 16'h0000}));
    req = 4'b0001;
    wait_sread("t4_sread", 10, n);
    wait_ack("t4_ack", 40, n);
    check("t4_timeout_latency", 32'(n), 32'd9);
    check("t4_timeout_err", 32'(timeout_err), 32'd1);
    req = '0;
    repeat (3) @(negedge CLK);
    br_never = 1'b0;
    br_delay = 1;
    br_data  = 16'h5A5A;
    set_addr(2, 24'h00F00D);
    addr_q.push_back(24'h00F00D);
    sb.push_back(exp_t'({4'b0100, 16'h5A5A}));
    req = 4'b0100;
    wait_sread("t4b_sread", 10, n);
    wait_ack("t4b_ack", 20, n);
    check("t4b_ack_latency", 32'(n), 32'd2);
    req = '0;
    repeat (2) @(negedge CLK);
    check("t4b_timeout_sticky", 32'(timeout_err), 32'd1);

    // Reset while waiting for the bridge: read abandoned, late s_ready ignored.
    br_delay = 6;
    br_data  = 16'hDEAD;
    set_addr(0, 24'h000777);
    addr_q.push_back(24'h000777);
    req = 4'b0001;
    wait_sread("t6_sread", 10, n);
    repeat (2) @(negedge CLK);
    I_RESET_L = 1'b0;
    req       = '0;
    @(negedge CLK);
    I_RESET_L = 1'b1;
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_ack", 32'(ack), 32'd0);
    check("t6_timeout_cleared", 32'(timeout_err), 32'd0);
    check("t6_s_addr", 32'(s_addr), 32'd0);
    repeat (10) @(negedge CLK);
    check("t6_busy_after", 32'(busy), 32'd0);
    check("t6_rd_data", 32'(rd_data), 32'd0);

    check("sb_drained", 32'(sb.size()), 32'd0);
    check("addr_q_drained", 32'(addr_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
